// File: rtl/dpi_ctx_pkg.sv
// Shared types and constants for the DFA context scheduler.
package dpi_ctx_pkg;

    localparam int STATE_W_DEF = 11;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        SAVE   = 2'd3
    } fsm_t;

    function automatic int fid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpi_rr_arb.sv
// Combinational round-robin arbiter: search starts one past the last granted flow.
module dpi_rr_arb
    import dpi_ctx_pkg::*;
#(
    parameter int  NUM_FLOWS = 4,
    localparam int FID_W     = fid_w(NUM_FLOWS)
) (
    input  logic [NUM_FLOWS-1:0] req,
    input  logic [FID_W-1:0]     last_grant,
    output logic [FID_W-1:0]     gnt_id,
    output logic                 gnt_vld
);

    int idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_FLOWS; i++) begin
            idx = (int'(last_grant) + i) % NUM_FLOWS;
            if (!gnt_vld && req[idx]) begin
                gnt_id  = FID_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpi_ctx_sched.sv
// Time-shares one DFA engine across NUM_FLOWS byte streams with per-flow saved state.
// Optional per-flow match counters with `define DPI_CTX_MATCH_CNT_EN.
module dpi_ctx_sched
    import dpi_ctx_pkg::*;
#(
    parameter int  NUM_FLOWS = 4,
    parameter int  STATE_W   = STATE_W_DEF,
    parameter int  MAX_BURST = 16,
    localparam int FID_W     = fid_w(NUM_FLOWS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_FLOWS*8-1:0] req_char,
    input  logic [NUM_FLOWS-1:0]   req_vld,
    input  logic [NUM_FLOWS-1:0]   req_last,
    output logic [NUM_FLOWS-1:0]   req_rdy,
    input  logic                   ctx_clr,
    input  logic [FID_W-1:0]       ctx_clr_id,
    output logic [7:0]             dfa_char,
    output logic                   dfa_char_vld,
    output logic [STATE_W-1:0]     dfa_state_in,
    output logic                   dfa_state_in_vld,
    input  logic [STATE_W-1:0]     dfa_state_out,
    input  logic                   dfa_accept,
`ifdef DPI_CTX_MATCH_CNT_EN
    input  logic [FID_W-1:0]       cnt_sel,
    output logic [CNT_W-1:0]       cnt_out,
`endif
    output logic                   match_vld,
    output logic [FID_W-1:0]       match_flow,
    output logic                   busy
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);

    fsm_t               state;
    logic [FID_W-1:0]   grant, last_grant, arb_id;
    logic               arb_vld;
    logic [BEAT_W-1:0]  beat;
    logic               end_last, clr_pend;
    logic [STATE_W-1:0] ctx [NUM_FLOWS];
    logic               in_stream, cur_vld, cur_last, consume;

    dpi_rr_arb #(.NUM_FLOWS(NUM_FLOWS)) u_arb (
        .req        (req_vld),
        .last_grant (last_grant),
        .gnt_id     (arb_id),
        .gnt_vld    (arb_vld)
    );

    assign in_stream = (state == STREAM);
    assign cur_vld   = req_vld[grant];
    assign cur_last  = req_last[grant];
    assign consume   = in_stream & cur_vld;

    always_comb begin
        req_rdy = '0;
        if (in_stream) req_rdy[grant] = 1'b1;
    end

    assign dfa_char         = in_stream ? req_char[8*int'(grant) +: 8] : 8'h00;
    assign dfa_char_vld     = consume;
    assign dfa_state_in_vld = (state == LOAD);
    assign dfa_state_in     = (state == LOAD) ? ctx[grant] : '0;
    assign busy             = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= FID_W'(NUM_FLOWS - 1);
            beat       <= '0;
            end_last   <= 1'b0;
            clr_pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (arb_vld) begin
                    grant    <= arb_id;
                    beat     <= '0;
                    end_last <= 1'b0;
                    clr_pend <= 1'b0;
                    state    <= LOAD;
                end
                LOAD: state <= STREAM;
                STREAM: begin
                    if (!cur_vld) begin
                        state <= SAVE;
                    end else begin
                        beat <= beat + 1'b1;
                        if (cur_last) begin
                            end_last <= 1'b1;
                            state    <= SAVE;
                        end else if (beat == BEAT_W'(MAX_BURST - 1)) begin
                            state <= SAVE;
                        end
                    end
                end
                SAVE: begin
                    last_grant <= grant;
                    beat       <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A clear aimed at the in-flight flow must survive the write-back.
            if (ctx_clr && ctx_clr_id == grant && (state == LOAD || state == STREAM))
                clr_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) ctx[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (ctx_clr && ctx_clr_id == FID_W'(i))
                    ctx[i] <= '0;
                else if (state == SAVE && grant == FID_W'(i))
                    ctx[i] <= (end_last || clr_pend) ? '0 : dfa_state_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vld  <= 1'b0;
            match_flow <= '0;
        end else begin
            match_vld  <= consume & dfa_accept;
            match_flow <= grant;
        end
    end

`ifdef DPI_CTX_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt [NUM_FLOWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) cnt[i] <= '0;
            cnt_out <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (ctx_clr && ctx_clr_id == FID_W'(i))
                    cnt[i] <= '0;
                else if (match_vld && match_flow == FID_W'(i) && cnt[i] != '1)
                    cnt[i] <= cnt[i] + 1'b1;
            end
            cnt_out <= cnt[cnt_sel];
        end
    end
`endif

endmodule

// File: doc/dpi_ctx_sched.md
# dpi_ctx_sched

Context scheduler that time-shares one regex DFA engine (8-bit char in, 11-bit state in/out, combinational accept) among NUM_FLOWS byte streams. Each flow's DFA state is saved in a context table while the flow is idle. On grant, the saved state is restored into the engine, a bounded burst of characters is streamed, and the resulting state is written back. Sits between the per-flow packet-payload FIFOs and the DFA instance; matches are reported tagged with the flow id.

## Interface
- NUM_FLOWS, 4, number of requesting flows (2..16)
- STATE_W, 11, DFA state width
- MAX_BURST, 16, max characters per grant (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_char  in  NUM_FLOWS*8  per-flow character, flow i at [8i+7:8i]
- req_vld  in  NUM_FLOWS  per-flow character valid
- req_last  in  NUM_FLOWS  character is last of packet
- req_rdy  out  NUM_FLOWS  per-flow ready; char consumed when vld&rdy
- ctx_clr  in  1  clear one flow context to 0
- ctx_clr_id  in  FID_W  flow to clear (FID_W = clog2(NUM_FLOWS))
- dfa_char  out  8  char to engine
- dfa_char_vld  out  1  char valid to engine
- dfa_state_in  out  STATE_W  state to load
- dfa_state_in_vld  out  1  load strobe
- dfa_state_out  in  STATE_W  engine current state
- dfa_accept  in  1  engine accept (combinational on dfa_char)
- match_vld  out  1  registered match pulse
- match_flow  out  FID_W  flow of match
- busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, LOAD, STREAM, SAVE.
- IDLE: if any req_vld, round-robin grant starting at (last_grant+1) mod NUM_FLOWS; -> LOAD. Else stay.
- LOAD: dfa_state_in = ctx[grant], dfa_state_in_vld = 1 for exactly one cycle; -> STREAM.
- STREAM: req_rdy[grant] = 1, all other req_rdy = 0; dfa_char = req_char of grant, dfa_char_vld = req_vld[grant]. Beat counter increments per consumed char.
- Leave STREAM -> SAVE on the first of: consumed char with req_last; beat count reaching MAX_BURST; req_vld[grant] low in any STREAM cycle (zero-char burst allowed).
- SAVE: ctx[grant] <= 0 if the burst ended on req_last, else dfa_state_out; last_grant <= grant; -> IDLE.
- match_vld/match_flow registered from (dfa_char_vld & dfa_accept, grant).
- ctx_clr writes 0 to ctx[ctx_clr_id] in any state. If it coincides with SAVE to the same flow, clear wins. If it targets the flow currently in LOAD/STREAM, the write-back still clears it at SAVE.
- dfa_state_in_vld and dfa_char_vld are never asserted together.

## Timing
- Reset (async assert, sync-safe release): FSM IDLE, all ctx entries 0, last_grant = NUM_FLOWS-1 (first grant goes to flow 0), beat counter 0. All outputs 0; busy 0.
- Request to first consumed char: 2 cycles (IDLE grant, LOAD).
- Per-grant overhead: 3 cycles (IDLE, LOAD, SAVE). Throughput 1 char/cycle in STREAM.
- match_vld asserts the cycle after the accepting character, for 1 cycle.
- Reset mid-burst: burst aborted, context of the granted flow is 0 (no partial write-back).

## Configuration
- DPI_CTX_MATCH_CNT_EN defined: per-flow 16-bit saturating match counters (stop at 0xFFFF), incremented with match_vld. Adds ports cnt_sel (in, FID_W) and cnt_out (out, 16, registered, 1-cycle latency). Counters reset to 0, and are also cleared by ctx_clr for that flow.
- Undefined: no counters, no cnt_sel/cnt_out ports; all other behaviour identical.

## Structure
- Package dpi_ctx_pkg: STATE_W default, FSM state enum (IDLE/LOAD/STREAM/SAVE), FID_W helper function, counter width constant.
- Sub-module dpi_rr_arb: NUM_FLOWS round-robin arbiter taking req vector and last_grant, producing grant id and grant valid (combinational).
- Context table: flops (NUM_FLOWS x STATE_W); no RAM.

## Test plan
- Single flow 0, ftp-style DFA, chars "MKD\n" with last on '\n' -> 1 burst, one match_vld with match_flow=0 one cycle after 'M' if the pattern accepts; ctx[0]=0 after SAVE.
- Flows 0 and 1 both valid continuously, MAX_BURST=4 -> grants alternate 0,1,0,1; each burst consumes exactly 4 chars; 3-cycle gap between bursts.
- Flow 2 sends "MK", deasserts, flow 3 bursts, flow 2 resumes "D" -> DFA state continuity: state loaded for flow 2 equals state saved after "MK".
- ctx_clr_id=1 pulsed in the SAVE cycle of flow 1 -> ctx[1]=0 and the next LOAD for flow 1 drives dfa_state_in=0.
- Assert rst_n low mid-STREAM -> all outputs 0 immediately; after release the first grant goes to flow 0 with dfa_state_in=0.
- With DPI_CTX_MATCH_CNT_EN: 3 matches on flow 1 -> cnt_sel=1 gives cnt_out=3 one cycle later; force 0xFFFF then one more match -> stays 0xFFFF.
